// File: rtl/irq_arbiter_avl.sv
// Avalon-MM interrupt collector: sync + edge capture of active-low lines, mask, round-robin grant to one CPU irq.
// int_n_in low at edge k -> PENDING at k+SYNC_STAGES -> irq after k+SYNC_STAGES+1; readdata valid one cycle after address.
module irq_arbiter_avl #(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               read_n,
    input  logic               write_n,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    input  logic [NUM_SRC-1:0] int_n_in,
    output logic               irq
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACTIVE  = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];
    logic [NUM_SRC-1:0] r_asserted_d;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic [4:0]         r_vec;
    logic [4:0]         r_rr_ptr;
    logic [31:0]        r_rdata;
    logic               r_irq;
    state_t             r_state;

    logic [NUM_SRC-1:0] w_asserted;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_elig;
    logic [NUM_SRC-1:0] w_w1c;
    logic [NUM_SRC-1:0] w_ack_clr;
    logic [NUM_SRC-1:0] w_vec_oh;
    logic               w_wr;
    logic               w_wr_pend;
    logic               w_wr_mask;
    logic               w_wr_ack;
    logic               w_ack_hit;
    logic               w_w1c_hit;
    logic               w_mask_drop;
    logic               w_found;
    logic [4:0]         w_sel;
    logic [4:0]         w_vec_nxt;
    logic [4:0]         w_rr_nxt;
    logic [4:0]         w_rr_inc;
    int                 w_idx;
    logic [31:0]        w_rdata;
    state_t             w_state_nxt;
    logic               w_unused;

    // read_n is not needed: readdata tracks the address mux every cycle
    assign w_unused = ^{read_n, writedata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '1;
        end else begin
            r_sync[0] <= int_n_in;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    assign w_asserted = ~r_sync[SYNC_STAGES-1];
    assign w_rise     = w_asserted & ~r_asserted_d;
    assign w_elig     = r_pending & r_mask;

    assign w_wr      = chipselect & ~write_n;
    assign w_wr_pend = w_wr & (address == 3'd1);
    assign w_wr_mask = w_wr & (address == 3'd2);
    assign w_wr_ack  = w_wr & (address == 3'd4);
    assign w_w1c     = w_wr_pend ? writedata[NUM_SRC-1:0] : '0;

    always_comb begin
        w_vec_oh = '0;
        for (int i = 0; i < NUM_SRC; i++) w_vec_oh[i] = (r_vec == 5'(i));
    end

    assign w_ack_hit   = w_wr_ack & (writedata[4:0] == r_vec);
    assign w_w1c_hit   = |(w_w1c & w_vec_oh);
    assign w_mask_drop = w_wr_mask & ~(|(writedata[NUM_SRC-1:0] & w_vec_oh));
    assign w_rr_inc    = (r_vec == 5'(NUM_SRC-1)) ? 5'd0 : r_vec + 5'd1;

    // Round-robin search upward from rr_ptr with wrap, no divider needed
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
        for (int j = 0; j < NUM_SRC; j++) begin
            w_idx = int'(r_rr_ptr) + j;
            if (w_idx >= NUM_SRC) w_idx = w_idx - NUM_SRC;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!w_found && (i == w_idx) && w_elig[i]) begin
                    w_found = 1'b1;
                    w_sel   = 5'(i);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_rr_nxt    = r_rr_ptr;
        w_ack_clr   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_vec_nxt   = w_sel;
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (w_ack_hit || w_w1c_hit) begin
                    w_ack_clr   = w_vec_oh;
                    w_rr_nxt    = w_rr_inc;
                    w_state_nxt = S_HOLDOFF;
                end else if (w_mask_drop) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLDOFF: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            3'd0:    w_rdata = 32'(w_asserted);
            3'd1:    w_rdata = 32'(r_pending);
            3'd2:    w_rdata = 32'(r_mask);
            3'd3:    w_rdata = {(r_state == S_ACTIVE), 26'd0, r_vec};
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_asserted_d <= '0;
            r_pending    <= '0;
            r_mask       <= '0;
            r_vec        <= '0;
            r_rr_ptr     <= '0;
            r_rdata      <= '0;
            r_irq        <= 1'b0;
            r_state      <= S_IDLE;
        end else begin
            r_asserted_d <= w_asserted;
            // A fresh edge wins over any clear landing in the same cycle
            r_pending    <= (r_pending & ~w_w1c & ~w_ack_clr) | w_rise;
            if (w_wr_mask) r_mask <= writedata[NUM_SRC-1:0];
            r_vec        <= w_vec_nxt;
            r_rr_ptr     <= w_rr_nxt;
            r_rdata      <= w_rdata;
            r_irq        <= (w_state_nxt == S_ACTIVE);
            r_state      <= w_state_nxt;
        end
    end

    assign readdata = r_rdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_irq_arbiter_avl.sv
// Directed bench for irq_arbiter_avl: register map, latency, round-robin, ack/mask/W1C handling, async reset.
module tb_irq_arbiter_avl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [3:0]  int_n_in = 4'hF;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    irq_arbiter_avl #(.NUM_SRC(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .int_n_in   (int_n_in),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("irq_in_reset", 32'(irq), 32'd0);
        check("rdata_in_reset", readdata, 32'd0);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) check_reg($sformatf("reset_reg%0d", a), 3'(a), 32'd0);
        check("irq_after_reset", 32'(irq), 32'd0);
        bus_write(3'd2, 32'hFFFF_FFFF);
        check_reg("mask_upper_zero", 3'd2, 32'h0000_000F);
        bus_write(3'd2, 32'h0000_000F);
        check_reg("mask_rdback", 3'd2, 32'h0000_000F);

        // Single source latency and ack
        bus_write(3'd2, 32'h1);
        @(negedge clk);
        address = 3'd1; chipselect = 1'b1; read_n = 1'b0; int_n_in[0] = 1'b0;
        @(negedge clk);
        check("lat_irq_k", 32'(irq), 32'd0);
        @(negedge clk);
        check("lat_irq_k1", 32'(irq), 32'd0);
        @(negedge clk);
        check("lat_pend_k2", readdata, 32'd0);
        check("lat_irq_k2", 32'(irq), 32'd0);
        @(negedge clk);
        check("lat_pend_k3", readdata, 32'h1);
        check("lat_irq_k3", 32'(irq), 32'd1);
        chipselect = 1'b0; read_n = 1'b1;
        check_reg("raw_src0", 3'd0, 32'h1);
        check_reg("vector_src0", 3'd3, 32'h8000_0000);
        bus_write(3'd4, 32'd0);
        check("ack0_irq_low", 32'(irq), 32'd0);
        @(negedge clk);
        check("ack0_irq_still_low", 32'(irq), 32'd0);
        check_reg("ack0_pend_clear", 3'd1, 32'd0);
        check_reg("ack0_level_no_repend", 3'd1, 32'd0);
        check_reg("ack0_vector_invalid", 3'd3, 32'h0000_0000);

        // Round-robin: rr_ptr=1, sources 0 and 2 together -> 2 first
        int_n_in = 4'hF;
        repeat (4) @(negedge clk);
        bus_write(3'd2, 32'hF);
        @(negedge clk);
        int_n_in = 4'b1010;
        repeat (5) @(negedge clk);
        check("rr_irq", 32'(irq), 32'd1);
        check_reg("rr_vector_2", 3'd3, 32'h8000_0002);
        bus_write(3'd4, 32'd2);
        check("rr_holdoff_irq", 32'(irq), 32'd0);
        @(negedge clk);
        check("rr_idle_irq", 32'(irq), 32'd0);
        @(negedge clk);
        check("rr_regrant_irq", 32'(irq), 32'd1);
        check_reg("rr_vector_0", 3'd3, 32'h8000_0000);
        bus_write(3'd4, 32'd0);
        check("rr_ack0_irq", 32'(irq), 32'd0);
        repeat (2) @(negedge clk);
        check("rr_ack0_irq_stays", 32'(irq), 32'd0);
        check_reg("rr_pend_empty", 3'd1, 32'd0);

        // Wrong-index ack ignored, then mask drop
        int_n_in = 4'hF;
        repeat (3) @(negedge clk);
        int_n_in[2] = 1'b0;
        repeat (5) @(negedge clk);
        check("wrong_ack_pre_irq", 32'(irq), 32'd1);
        check_reg("wrong_ack_pre_vec", 3'd3, 32'h8000_0002);
        bus_write(3'd4, 32'd1);
        check("wrong_ack_irq", 32'(irq), 32'd1);
        check_reg("wrong_ack_vec", 3'd3, 32'h8000_0002);
        bus_write(3'd2, 32'hB);
        check("mask_drop_irq", 32'(irq), 32'd0);
        check_reg("mask_drop_pend", 3'd1, 32'h4);
        check("mask_drop_irq_stays", 32'(irq), 32'd0);
        bus_write(3'd1, 32'h4);
        check_reg("w1c_clears", 3'd1, 32'd0);
        int_n_in = 4'hF;

        // Set wins over same-cycle W1C
        bus_write(3'd2, 32'd0);
        repeat (3) @(negedge clk);
        int_n_in[3] = 1'b0;
        @(negedge clk);
        bus_write(3'd1, 32'h8);
        check_reg("set_wins_w1c", 3'd1, 32'h8);
        check("set_wins_irq", 32'(irq), 32'd0);

        // W1C on granted source acts as ack
        bus_write(3'd2, 32'h8);
        repeat (2) @(negedge clk);
        check("w1c_ack_pre_irq", 32'(irq), 32'd1);
        check_reg("w1c_ack_pre_vec", 3'd3, 32'h8000_0003);
        bus_write(3'd1, 32'h8);
        check("w1c_ack_irq", 32'(irq), 32'd0);
        check_reg("w1c_ack_pend", 3'd1, 32'd0);
        int_n_in[3] = 1'b1;
        repeat (3) @(negedge clk);
        int_n_in[3] = 1'b0;
        repeat (5) @(negedge clk);
        check("regrant3_irq", 32'(irq), 32'd1);
        check_reg("regrant3_vec", 3'd3, 32'h8000_0003);

        // Async reset while active
        @(negedge clk);
        reset_n = 1'b0;
        int_n_in = 4'hF;
        #1;
        check("async_reset_irq", 32'(irq), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) check_reg($sformatf("post_reset_reg%0d", a), 3'(a), 32'd0);
        check("post_reset_irq", 32'(irq), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
